// File: rtl/renas_line_refill_pkg.sv
// Shared types for the line refill engine: AHB master/slave bundles,
// AHB encodings and the refill FSM state enum.
package renas_line_refill_pkg;

    // Default number of 32-bit words in one L2 line.
    localparam int DEF_LINE_WORDS = 4;

    // AHB encodings used by the engine.
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    // Signals driven by the AHB master towards the slave.
    typedef struct packed {
        logic [31:0] haddr;
        logic        hwrite;
        logic [31:0] hwdata;
        logic [1:0]  htrans;
        logic [2:0]  hsize;
        logic [2:0]  hburst;
    } mas_send_type;

    // Signals returned by the AHB slave.
    typedef struct packed {
        logic        hreadyout;
        logic        hresp;
        logic [31:0] hrdata;
    } slv_send_type;

    // Refill engine states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } refill_state_e;

endpackage

// File: rtl/renas_line_refill.sv
// Line transfer engine: turns one line refill / write-back request into
// LINE_WORDS single-word AHB transfers separated by idle gaps so the
// slave's req/ack handshake can re-arm between words.
//
// Request handshake: a request is accepted on a rising clk_l2 edge where
// req_valid and req_ready are both high; req_addr, req_write and req_wline
// are sampled on that edge only. Completion is signalled by a single-cycle
// rsp_valid pulse; rsp_err and rsp_rline are meaningful while it is high.
module renas_line_refill
    import renas_line_refill_pkg::*;
#(
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 64
) (
    input  logic                    clk_l2,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [31:0]             req_addr,
    input  logic [32*LINE_WORDS-1:0] req_wline,
    output logic                    rsp_valid,
    output logic [32*LINE_WORDS-1:0] rsp_rline,
    output logic                    rsp_err,
    output logic                    mem_hsel,
    output mas_send_type            mem_out,
    input  slv_send_type            mem_in,
    output refill_state_e           dbg_state
);

    localparam int IW = $clog2(LINE_WORDS);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(LINE_WORDS - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    refill_state_e                state_q, state_d;
    logic [29-IW:0]               base_q, base_d;   // line-aligned address bits
    logic                         write_q, write_d;
    logic [LINE_WORDS-1:0][31:0]  line_q, line_d;   // write source / read assembly
    logic [LINE_WORDS-1:0][31:0]  rline_q, rline_d; // last completed refill line
    logic [IW-1:0]                idx_q, idx_d;
    logic [GW-1:0]                gap_q, gap_d;
    logic [TW-1:0]                tmo_q, tmo_d;
    logic                         err_q, err_d;
    logic [31:0]                  word_addr;

    // The in-line offset bits of req_addr are dropped on purpose.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^req_addr[IW+1:0];

    assign rsp_rline = rline_q;
    assign dbg_state = state_q;
    // Word index sits directly in the offset field, so it can never carry out of the line.
    assign word_addr = {base_q, idx_q, 2'b00};

    // Next-state logic, counters, data capture and bus outputs.
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        write_d   = write_q;
        line_d    = line_q;
        rline_d   = rline_q;
        idx_d     = idx_q;
        gap_d     = gap_q;
        tmo_d     = tmo_q;
        err_d     = err_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        mem_hsel  = 1'b0;
        mem_out   = '0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    base_d  = req_addr[31:IW+2];
                    write_d = req_write;
                    line_d  = req_wline;
                    idx_d   = '0;
                    gap_d   = '0;
                    tmo_d   = '0;
                    err_d   = 1'b0;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                mem_hsel       = 1'b1;
                mem_out.haddr  = word_addr;
                mem_out.hwrite = write_q;
                mem_out.hwdata = line_q[idx_q];
                mem_out.htrans = HTRANS_NONSEQ;
                mem_out.hsize  = HSIZE_WORD;
                mem_out.hburst = HBURST_SINGLE;
                tmo_d          = tmo_q + 1'b1;
                if (mem_in.hreadyout) begin
                    if (!write_q) begin
                        line_d[idx_q] = mem_in.hrdata;
                    end
                    if (mem_in.hresp) begin
                        err_d = 1'b1;
                    end
                    gap_d   = '0;
                    state_d = (idx_q == LAST_IDX) ? DONE : GAP;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
                // Publish the assembled line as DONE is entered; write-backs leave it alone.
                if (state_d == DONE && !write_q) begin
                    rline_d = line_d;
                end
            end
            GAP: begin
                mem_out.haddr  = word_addr;
                mem_out.hwrite = write_q;
                mem_out.hwdata = line_q[idx_q];
                gap_d          = gap_q + 1'b1;
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    idx_d   = idx_q + 1'b1;
                    tmo_d   = '0;
                    state_d = ADDR;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any line in flight.
    always_ff @(posedge clk_l2 or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            write_q <= 1'b0;
            line_q  <= '0;
            rline_q <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            write_q <= write_d;
            line_q  <= line_d;
            rline_q <= rline_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_renas_line_refill.sv
// Bench for renas_line_refill: AHB slave model, directed and random line
// requests, a line-level reference model feeding expected queues, and a
// monitor that checks every bus word and every completion.
module tb_renas_line_refill;
    import renas_line_refill_pkg::*;

    localparam int LW  = 4;
    localparam int GAP = 2;
    localparam int TMO = 64;
    localparam int W   = 32 * LW;

    // ---------------- clock / reset ----------------
    logic          clk_l2 = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_write = 1'b0;
    logic [31:0]   req_addr = '0;
    logic [W-1:0]  req_wline = '0;
    logic          req_ready;
    logic          rsp_valid;
    logic [W-1:0]  rsp_rline;
    logic          rsp_err;
    logic          mem_hsel;
    mas_send_type  mem_out;
    slv_send_type  mem_in;
    refill_state_e dbg_state;

    always #5 clk_l2 = ~clk_l2;

    int cyc = 0;
    always @(posedge clk_l2) cyc <= cyc + 1;

    renas_line_refill #(
        .LINE_WORDS(LW),
        .GAP_CYCLES(GAP),
        .TIMEOUT   (TMO)
    ) dut (
        .clk_l2   (clk_l2),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wline(req_wline),
        .rsp_valid(rsp_valid),
        .rsp_rline(rsp_rline),
        .rsp_err  (rsp_err),
        .mem_hsel (mem_hsel),
        .mem_out  (mem_out),
        .mem_in   (mem_in),
        .dbg_state(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0]  exp_line_q[$];
    logic          exp_err_q[$];
    int            exp_cyc_q[$];
    logic [31:0]   exp_addr_q[$];
    logic [31:0]   exp_wd_q[$];
    logic          exp_wr_q[$];
    logic [W-1:0]  rline_model = '0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_event(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s actual=event required=no_event (t=%0t)", name, $time);
    endtask

    // ---------------- AHB slave model ----------------
    int          slv_lat   = 1;
    int          slv_err   = -1;
    bit          slv_hang  = 1'b0;
    bit          slv_noise = 1'b0;
    logic [31:0] slv_key   = 32'hA5A5_A5A5;
    logic [31:0] smem [logic [31:0]];

    function automatic logic [31:0] smem_rd(input logic [31:0] a);
        return smem.exists(a) ? smem[a] : 32'h0;
    endfunction

    // Slave: answers after slv_lat selected cycles with a one-cycle hreadyout pulse.
    initial begin
        int s_cnt = 0;
        int s_word = 0;
        mem_in = '0;
        forever begin
            @(posedge clk_l2);
            #1;
            mem_in.hreadyout = 1'b0;
            mem_in.hresp     = 1'b0;
            mem_in.hrdata    = $urandom;
            if (req_ready) s_word = 0;
            if (mem_hsel) begin
                s_cnt++;
                if (!slv_hang && s_cnt >= slv_lat) begin
                    mem_in.hreadyout = 1'b1;
                    mem_in.hrdata    = mem_out.haddr ^ slv_key;
                    mem_in.hresp     = (s_word == slv_err);
                    if (mem_out.hwrite) smem[mem_out.haddr] = mem_out.hwdata;
                    s_word++;
                    s_cnt = 0;
                end
            end else begin
                s_cnt = 0;
                if (slv_noise) begin
                    mem_in.hreadyout = 1'($urandom_range(0, 1));
                    mem_in.hresp     = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    // ---------------- monitor ----------------
    // Checks every word presented on the bus and every completion pulse.
    initial begin
        logic        prev_hsel = 1'b0;
        int          words_seen = 0;
        int          low_cnt = 0;
        bit          ready_next = 1'b0;
        logic [31:0] cur_addr = '0;
        logic [31:0] cur_wd = '0;
        logic        cur_wr = 1'b0;
        forever begin
            @(negedge clk_l2);
            if (rst) begin
                prev_hsel = 1'b0; words_seen = 0; low_cnt = 0; ready_next = 1'b0;
            end else begin
                if (ready_next) begin
                    check("req_ready_after_rsp", W'(req_ready), W'(1'b1));
                    check("rsp_valid_one_cycle", W'(rsp_valid), W'(1'b0));
                    ready_next = 1'b0;
                end
                if (mem_hsel) begin
                    if (!prev_hsel) begin
                        if (exp_addr_q.size() == 0) begin
                            fail_event("unexpected_word");
                        end else begin
                            cur_addr = exp_addr_q.pop_front();
                            cur_wd   = exp_wd_q.pop_front();
                            cur_wr   = exp_wr_q.pop_front();
                            check("haddr", W'(mem_out.haddr), W'(cur_addr));
                            check("hwrite", W'(mem_out.hwrite), W'(cur_wr));
                            check("htrans", W'(mem_out.htrans), W'(HTRANS_NONSEQ));
                            check("hsize", W'(mem_out.hsize), W'(HSIZE_WORD));
                            check("hburst", W'(mem_out.hburst), W'(HBURST_SINGLE));
                            if (words_seen > 0) check("gap_len", W'(low_cnt), W'(GAP));
                            words_seen++;
                        end
                    end else begin
                        check("haddr_held", W'(mem_out.haddr), W'(cur_addr));
                    end
                    if (cur_wr) check("hwdata", W'(mem_out.hwdata), W'(cur_wd));
                    low_cnt = 0;
                end else begin
                    low_cnt++;
                end
                if (rsp_valid) begin
                    if (exp_line_q.size() == 0) begin
                        fail_event("unexpected_rsp");
                    end else begin
                        logic [W-1:0] el;
                        logic         ee;
                        int           ec;
                        el = exp_line_q.pop_front();
                        ee = exp_err_q.pop_front();
                        ec = exp_cyc_q.pop_front();
                        check("rsp_rline", rsp_rline, el);
                        check("rsp_err", W'(rsp_err), W'(ee));
                        check("rsp_cycle", W'(cyc), W'(ec));
                        check("words_left", W'(exp_addr_q.size()), W'(0));
                    end
                    words_seen = 0;
                    ready_next = 1'b1;
                end
                prev_hsel = mem_hsel;
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [W-1:0] rand_line();
        logic [W-1:0] l;
        for (int i = 0; i < LW; i++) l[32*i +: 32] = $urandom;
        return l;
    endfunction

    // Issues one request and pushes what the line-level model predicts.
    task automatic issue_req(input logic wr, input logic [31:0] addr, input logic [W-1:0] wline,
                             input int lat, input int errw, input bit hang,
                             input logic [31:0] key, input bit noise);
        logic [31:0]  base;
        logic [W-1:0] line;
        int           nwords;
        int           c;
        @(negedge clk_l2);
        check("req_ready_idle", W'(req_ready), W'(1'b1));
        slv_lat = lat; slv_err = errw; slv_hang = hang; slv_key = key; slv_noise = noise;
        base   = addr & ~(32'(LW * 4) - 32'd1);
        nwords = hang ? 1 : LW;
        for (int i = 0; i < nwords; i++) begin
            exp_addr_q.push_back(base + 32'(4 * i));
            exp_wd_q.push_back(wline[32*i +: 32]);
            exp_wr_q.push_back(wr);
        end
        line = rline_model;
        if (!wr) begin
            for (int i = 0; i < LW; i++) line[32*i +: 32] = (base + 32'(4 * i)) ^ key;
            rline_model = line;
        end
        exp_line_q.push_back(line);
        exp_err_q.push_back(hang || (errw >= 0 && errw < LW));
        c = cyc;
        // Spec latency counts both the accepting cycle and the rsp_valid cycle.
        exp_cyc_q.push_back(hang ? c + 1 + TMO : c + (LW * lat + (LW - 1) * GAP + 2) - 1);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wline = wline;
        @(negedge clk_l2);
        req_valid = 1'b0;
        req_write = 1'($urandom_range(0, 1));
        req_addr  = $urandom;
        req_wline = rand_line();
    endtask

    task automatic wait_done();
        int n = 0;
        while (exp_line_q.size() != 0 && n < 2000) begin
            @(posedge clk_l2);
            n++;
        end
        if (exp_line_q.size() != 0) begin
            check("response_timeout", W'(exp_line_q.size()), W'(0));
            exp_line_q.delete(); exp_err_q.delete(); exp_cyc_q.delete();
            exp_addr_q.delete(); exp_wd_q.delete(); exp_wr_q.delete();
        end
        @(negedge clk_l2);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [W-1:0] wl;
        int           falls;
        logic         prev;

        // Reset values.
        repeat (3) @(negedge clk_l2);
        check("rst_req_ready", W'(req_ready), W'(1'b1));
        check("rst_rsp_valid", W'(rsp_valid), W'(1'b0));
        check("rst_rsp_err", W'(rsp_err), W'(1'b0));
        check("rst_rsp_rline", rsp_rline, '0);
        check("rst_hsel", W'(mem_hsel), W'(1'b0));
        check("rst_mem_out", W'(mem_out), '0);
        check("rst_state", W'(dbg_state), W'(IDLE));
        rst = 1'b0;

        // Refill from 0x2040, slave latency 3.
        issue_req(1'b0, 32'h0000_2040, rand_line(), 3, -1, 1'b0, 32'hA5A5_A5A5, 1'b0);
        wait_done();
        check("refill_word0", W'(rsp_rline[31:0]), W'(32'hA5A5_85E5));

        // Write-back to 0x100.
        wl = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        issue_req(1'b1, 32'h0000_0100, wl, 2, -1, 1'b0, 32'h0, 1'b0);
        wait_done();
        for (int i = 0; i < LW; i++)
            check("wb_mem", W'(smem_rd(32'h100 + 32'(4 * i))), W'(wl[32*i +: 32]));

        // Unaligned address.
        issue_req(1'b0, 32'h0000_205C, rand_line(), 1, -1, 1'b0, 32'h1234_5678, 1'b0);
        wait_done();

        // Error response on word 2.
        issue_req(1'b0, 32'h0000_3000, rand_line(), 2, 2, 1'b0, 32'h0F0F_0F0F, 1'b0);
        wait_done();

        // Slave never answers.
        issue_req(1'b1, 32'h0000_4000, rand_line(), 1, -1, 1'b1, 32'h0, 1'b0);
        wait_done();

        // Reset in the gap after word 1.
        issue_req(1'b0, 32'h0000_5000, rand_line(), 2, -1, 1'b0, 32'hDEAD_BEEF, 1'b0);
        falls = 0;
        prev  = 1'b0;
        for (int n = 0; n < 200 && falls < 2; n++) begin
            if (n > 0) @(negedge clk_l2);
            if (prev && !mem_hsel) falls++;
            prev = mem_hsel;
        end
        check("reached_gap1", W'(falls), W'(2));
        #2;
        rst = 1'b1;
        exp_line_q.delete(); exp_err_q.delete(); exp_cyc_q.delete();
        exp_addr_q.delete(); exp_wd_q.delete(); exp_wr_q.delete();
        rline_model = '0;
        #1;
        check("midrst_hsel", W'(mem_hsel), W'(1'b0));
        check("midrst_rsp_valid", W'(rsp_valid), W'(1'b0));
        check("midrst_state", W'(dbg_state), W'(IDLE));
        check("midrst_rline", rsp_rline, '0);
        repeat (2) @(negedge clk_l2);
        rst = 1'b0;
        issue_req(1'b0, 32'h0000_6010, rand_line(), 2, -1, 1'b0, 32'h5555_AAAA, 1'b0);
        wait_done();

        // Random traffic with hreadyout/hresp noise outside ADDR.
        for (int t = 0; t < 20; t++) begin
            logic        wr;
            logic [31:0] a;
            int          ew;
            wr = 1'($urandom_range(0, 1));
            a  = $urandom & 32'h000F_FFFF;
            ew = $urandom_range(0, 2 * LW - 1);
            wl = rand_line();
            issue_req(wr, a, wl, $urandom_range(1, 4), ew, 1'b0, $urandom, 1'b1);
            wait_done();
            if (wr) begin
                for (int i = 0; i < LW; i++)
                    check("rand_wb_mem", W'(smem_rd((a & ~32'(LW * 4 - 1)) + 32'(4 * i))),
                          W'(wl[32*i +: 32]));
            end
        end

        repeat (3) @(negedge clk_l2);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Overall time bound.
    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
